popcount_serial: RTL and testbench

Multi-cycle population-count unit that consumes a WIDTH-bit operand five bits per cycle, reduces each 5-bit group through the team's 5:3 counter, and accumulates the weighted counter outputs (s=1, c1=2, c2=4) into a binary count. It sits on the consumer side of the 5:3 counter interface. It serves the multiplier's operand-analysis path, for example zero-skipping and partial-product density checks. Where area matters more than latency, it replaces a full combinational compressor tree.

---
 rtl/popcount_pkg.sv | 26 ++
 rtl/popcount_serial_five_three.sv | 26 ++
 rtl/popcount_serial.sv | 139 +++++++++++++
 tb/tb_popcount_serial.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared types and constants for the serial population-count unit.
`timescale 1ns/1ps

package popcount_pkg;

    // Control states of the serial popcount sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Arithmetic weights of the 5:3 counter outputs.
    localparam int unsigned W_S  = 1;
    localparam int unsigned W_C1 = 2;
    localparam int unsigned W_C2 = 4;

    // Bits consumed per RUN cycle.
    localparam int unsigned GROUP_W = 5;

    // Number of 5-bit groups (and RUN cycles) for a given operand width.
    function automatic int unsigned groups(input int unsigned width);
        return width / GROUP_W;
    endfunction

endpackage

// File: rtl/popcount_serial_five_three.sv
// 5:3 counter: compresses five equally weighted bits into a 3-bit count {c2,c1,s}.
`timescale 1ns/1ps

module five_three (
    input  logic [4:0] i_x,
    output logic       o_s_c,
    output logic       o_c1_c,
    output logic       o_c2_c
);

    logic w_s1;
    logic w_k1;
    logic w_k2;

    // Two chained full adders; their carries are both weight 2 and are merged below.
    always_comb begin
        w_s1  = i_x[0] ^ i_x[1] ^ i_x[2];
        w_k1  = (i_x[0] & i_x[1]) | (i_x[0] & i_x[2]) | (i_x[1] & i_x[2]);
        o_s_c = w_s1 ^ i_x[3] ^ i_x[4];
        w_k2  = (w_s1 & i_x[3]) | (w_s1 & i_x[4]) | (i_x[3] & i_x[4]);
        // k1 + k2 (each weight 2) expressed as a 2-bit value at weights 2 and 4.
        o_c1_c = w_k1 ^ w_k2;
        o_c2_c = w_k1 & w_k2;
    end

endmodule

// File: rtl/popcount_serial.sv
// Serial population count: one 5-bit group per cycle through a 5:3 counter into an accumulator.
`timescale 1ns/1ps

module popcount_serial
    import popcount_pkg::*;
#(
    parameter int unsigned WIDTH = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             data_in,
    output logic                         ready,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned G     = groups(WIDTH);
    localparam int unsigned IDX_W = (G > 1) ? $clog2(G) : 1;

    // Reject operand widths that do not split into whole 5-bit groups.
    generate
        if (WIDTH == 0 || (WIDTH % GROUP_W) != 0) begin : g_bad_width
            $error("popcount_serial: WIDTH must be a non-zero multiple of 5");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH-1:0]   w_sh_nxt;
    logic [CNT_W-1:0]   r_acc;
    logic [CNT_W-1:0]   w_acc_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               w_ready_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic               w_s;
    logic               w_c1;
    logic               w_c2;
    logic [2:0]         w_inc;
    logic [CNT_W-1:0]   w_acc_sum;
    logic               w_accept;
    logic               w_last;

    // Counter sees the lowest group of the shift register every cycle.
    five_three u_five_three (
        .i_x    (r_sh[4:0]),
        .o_s_c  (w_s),
        .o_c1_c (w_c1),
        .o_c2_c (w_c2)
    );

    // Weighted counter outputs and the running sum including this cycle's group.
    always_comb begin
        w_inc = (w_s  ? 3'(W_S)  : 3'd0)
              + (w_c1 ? 3'(W_C1) : 3'd0)
              + (w_c2 ? 3'(W_C2) : 3'd0);
        w_acc_sum = r_acc + CNT_W'(w_inc);
        w_accept  = start && r_ready;
        w_last    = (r_idx == IDX_W'(G - 1));
    end

    // Next-state, datapath and registered-flag decode.
    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_acc_nxt   = r_acc;
        w_idx_nxt   = r_idx;
        w_count_nxt = r_count;

        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                    w_sh_nxt    = data_in;
                    w_acc_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (r_state == DONE) begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                w_sh_nxt  = r_sh >> GROUP_W;
                w_acc_nxt = w_acc_sum;
                w_idx_nxt = r_idx + IDX_W'(1);
                if (w_last) begin
                    w_state_nxt = DONE;
                    w_count_nxt = w_acc_sum;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_ready_nxt = (w_state_nxt != RUN);
        w_busy_nxt  = (w_state_nxt == RUN);
        w_done_nxt  = (w_state_nxt == DONE);
    end

    // State, datapath and status registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_acc   <= w_acc_nxt;
            r_idx   <= w_idx_nxt;
            r_count <= w_count_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign count = r_count;

endmodule

// File: tb/tb_popcount_serial.sv
// Scoreboard bench for popcount_serial at WIDTH=20.
`timescale 1ns/1ps

module tb_popcount_serial;

    localparam int unsigned WIDTH = 20;
    localparam int unsigned CNT_W = 5;
    localparam int          G     = 4;

    typedef struct {
        int cnt;
        int acc_cyc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    popcount_serial #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Result monitor: every done pulse pops one expected result.
    // Accept edge k shows done in the cycle after edge k+G (cycle k+G+1).
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("count", int'(count), mon_e.cnt);
                check("latency", cyc - mon_e.acc_cyc, G);
            end
        end
    end

    // Waits (bounded) for ready, then issues one operation; call at a negedge.
    task automatic drive_op(input logic [WIDTH-1:0] d);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", int'(ready), 1);
        start   = 1'b1;
        data_in = d;
        sb.push_back('{$countones(d), cyc + 1});
        @(negedge clk);
        start   = 1'b0;
        data_in = WIDTH'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_n;
        int n;
        logic seen_done;

        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        #1;
        check("rst_ready", int'(ready), 1);
        check("rst_busy",  int'(busy),  0);
        check("rst_done",  int'(done),  0);
        check("rst_count", int'(count), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero operand: busy for exactly G cycles, then done.
        drive_op(20'h00000);
        busy_n    = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 20 && !seen_done; i++) begin
            if (busy) busy_n++;
            if (done) seen_done = 1'b1;
            else @(negedge clk);
        end
        check("zero_busy_cycles", busy_n, G);
        check("zero_done_seen", int'(seen_done), 1);
        wait_idle();

        // All ones: accumulator trace 5,10,15,20.
        drive_op(20'hFFFFF);
        for (int i = 1; i <= G; i++) begin
            @(negedge clk);
            check("ones_acc_trace", int'(dut.r_acc), 5 * i);
        end
        wait_idle();

        // Mixed pattern plus first and last group.
        drive_op(20'hA5A5A);
        wait_idle();
        drive_op(20'h00001);
        wait_idle();
        drive_op(20'h80000);
        wait_idle();

        // start during RUN is ignored.
        drive_op(20'h0F0F0);
        start   = 1'b1;
        data_in = 20'hFFFFF;
        check("run_ready_low", int'(ready), 0);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // start held through DONE: second operation accepted in the done cycle.
        start   = 1'b1;
        data_in = 20'h12345;
        sb.push_back('{$countones(20'h12345), cyc + 1});
        @(negedge clk);
        data_in = 20'hFFFFF;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_ready", int'(ready), 1);
        check("b2b_in_done", int'(done), 1);
        data_in = 20'h0000F;
        sb.push_back('{4, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset in the second RUN cycle.
        drive_op(20'hFFFFF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", int'(ready), 1);
        check("mid_rst_busy",  int'(busy),  0);
        check("mid_rst_done",  int'(done),  0);
        check("mid_rst_count", int'(count), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        drive_op(20'h00F0F);
        wait_idle();

        // Random operands with random gaps.
        for (int i = 0; i < 1000; i++) begin
            drive_op(WIDTH'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
